// File: rtl/field_row_reader_if.sv
// rtl/field_row_reader_if.sv - row fetch request/acknowledge bus between row reader and field store
interface field_row_reader_if #(
  parameter int COLS = 10
);
  logic              row_req;
  logic [4:0]        row_addr;
  logic              row_ack;
  logic [COLS-1:0]   row_occ;
  logic [7*COLS-1:0] row_color;

  modport master (
    output row_req,
    output row_addr,
    input  row_ack,
    input  row_occ,
    input  row_color
  );

  modport slave (
    input  row_req,
    input  row_addr,
    output row_ack,
    output row_occ,
    output row_color
  );
endinterface

// File: rtl/field_row_reader.sv
// rtl/field_row_reader.sv - playfield line fetcher and per-pixel cell lookup (optional grid: GRID_LINES_EN)
module field_row_reader #(
  parameter int FIELD_X0  = 240,
  parameter int FIELD_Y0  = 40,
  parameter int CELL_LOG2 = 4,
  parameter int ROWS      = 20,
  parameter int COLS      = 10,
  parameter int H_FETCH   = 640,
  parameter int H_LAST    = 799
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  field_row_reader_if.master bus,
  output logic               is_block,
  output logic [6:0]         block_color,
  output logic               in_field,
  output logic               underrun,
  output logic               is_grid
);

  localparam int         COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [9:0] X0    = 10'(FIELD_X0);
  localparam logic [9:0] X1    = 10'(FIELD_X0 + (COLS << CELL_LOG2));
  localparam logic [9:0] Y0    = 10'(FIELD_Y0);
  localparam logic [9:0] Y1    = 10'(FIELD_Y0 + (ROWS << CELL_LOG2));
  localparam logic [9:0] HF    = 10'(H_FETCH);
  localparam logic [9:0] HL    = 10'(H_LAST);
  localparam logic [6:0] EMPTY = 7'h7F;

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nx;

  logic [9:0]      ny, ny_off;
  logic            need;
  logic [4:0]      next_row;
  logic            fetch_pt, swap_pt;

  logic            shadow_valid;
  logic [COLS-1:0] shadow_occ, act_occ;
  logic [6:0]      shadow_col [COLS];
  logic [6:0]      act_col    [COLS];

  logic [9:0]      dx;
  logic [COL_W-1:0] col;
  logic            in_field_c;
  logic            cell_occ;
  logic [6:0]      cell_col;

  // Row needed by the line after the current one (frame wraps at line 524).
  always_comb begin
    ny       = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
    ny_off   = ny - Y0;
    need     = (ny >= Y0) && (ny < Y1);
    next_row = 5'(ny_off >> CELL_LOG2);
    fetch_pt = (DrawX == HF);
    swap_pt  = (DrawX == HL);
  end

  // Fetch FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Fetch FSM next state: launch once per line at the fetch point, hold until acknowledged.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (fetch_pt && need) state_nx = REQ;
      REQ:  if (bus.row_ack)      state_nx = IDLE;
    endcase
  end

  assign bus.row_req = (state == REQ);

  // Request address, shadow capture, end-of-line swap and sticky underrun.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bus.row_addr <= '0;
      shadow_valid <= 1'b0;
      shadow_occ   <= '0;
      act_occ      <= '0;
      underrun     <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        shadow_col[c] <= EMPTY;
        act_col[c]    <= EMPTY;
      end
    end else begin
      // A new fetch point drops whatever was captured late for the previous line.
      if (state == IDLE && fetch_pt) begin
        shadow_valid <= 1'b0;
        if (need) bus.row_addr <= next_row;
      end
      if (swap_pt) begin
        if (shadow_valid) begin
          act_occ      <= shadow_occ;
          act_col      <= shadow_col;
          shadow_valid <= 1'b0;
        end else begin
          act_occ <= '0;
          for (int c = 0; c < COLS; c++) act_col[c] <= EMPTY;
          if (need) underrun <= 1'b1;
        end
      end
      // Capture wins over the swap clear; data acked on the swap cycle waits for the next fetch point.
      if (state == REQ && bus.row_ack) begin
        shadow_occ   <= bus.row_occ;
        shadow_valid <= 1'b1;
        for (int c = 0; c < COLS; c++) shadow_col[c] <= bus.row_color[7*c +: 7];
      end
    end
  end

  // Cell lookup for the current pixel from the active line buffer.
  always_comb begin
    dx         = DrawX - X0;
    col        = COL_W'(dx >> CELL_LOG2);
    in_field_c = (DrawX >= X0) && (DrawX < X1) && (DrawY >= Y0) && (DrawY < Y1);
    cell_occ   = 1'b0;
    cell_col   = EMPTY;
    if (in_field_c) begin
      cell_occ = act_occ[col];
      cell_col = act_col[col];
    end
  end

  // Registered pixel outputs, one cycle behind DrawX/DrawY.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      is_block    <= 1'b0;
      block_color <= EMPTY;
      in_field    <= 1'b0;
    end else begin
      in_field    <= in_field_c;
      is_block    <= cell_occ;
      block_color <= cell_occ ? cell_col : EMPTY;
    end
  end

`ifdef GRID_LINES_EN
  localparam logic [9:0] CELL_MASK = 10'((1 << CELL_LOG2) - 1);
  logic [9:0] dy;
  assign dy = DrawY - Y0;

  // Grid marks the first pixel column and row of every in-field cell.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) is_grid <= 1'b0;
    else        is_grid <= in_field_c && (((dx & CELL_MASK) == '0) || ((dy & CELL_MASK) == '0));
  end
`else
  assign is_grid = 1'b0;
`endif

endmodule

// File: doc/field_row_reader.md
Name: field_row_reader

Overview:
- Read side of the playfield store.
- Once per VGA line, during horizontal blank, fetches the field row needed for the next line over a request/acknowledge interface into a shadow buffer. Swaps the shadow buffer into an active line buffer at end of line.
- For every pixel, emits occupancy and the 7-bit shape colour of the cell under DrawX/DrawY, registered, for the colour mapper.

Parameters:
FIELD_X0, 240, left pixel column of the playfield
FIELD_Y0, 40, top pixel row of the playfield
CELL_LOG2, 4, log2 of cell size in pixels (cell = 16x16)
ROWS, 20, field rows
COLS, 10, field columns
H_FETCH, 640, DrawX value at which the next-line fetch is launched
H_LAST, 799, last DrawX of a line (swap point)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-low reset
DrawX  in  10  current pixel column from VGA controller
DrawY  in  10  current pixel row from VGA controller
row_req  out  1  fetch request to field store
row_addr  out  5  row index requested, stable while row_req high
row_ack  in  1  store acknowledge; row_occ/row_color valid in the ack cycle
row_occ  in  COLS  occupancy bits of requested row, bit c = column c
row_color  in  7*COLS  colours, bits [7c+6:7c] = column c, 7'h7F = empty
is_block  out  1  pixel lies on an occupied cell
block_color  out  7  colour of that cell, 7'h7F when not is_block
in_field  out  1  pixel lies inside the playfield rectangle
underrun  out  1  sticky: a swap occurred without a completed fetch
is_grid  out  1  grid-line pixel (see Optional Feature)

Behaviour:
- Reset (async, Reset=0):
  - row_req=0, row_addr=0, is_block=0, block_color=7'h7F, in_field=0, underrun=0, is_grid=0.
  - FSM state=IDLE.
  - Both buffers cleared: occupancy 0, colours 7'h7F; shadow_valid=0.
- Next-line row:
  - ny = (DrawY==524) ? 0 : DrawY+1.
  - need = FIELD_Y0 <= ny < FIELD_Y0 + ROWS<<CELL_LOG2.
  - r = (ny-FIELD_Y0)>>CELL_LOG2, truncated to 5 bits.
- FSM states:
  - IDLE: on DrawX==H_FETCH and need, go to REQ with row_addr=r and row_req=1. If not need, stay in IDLE and set shadow_valid=0.
  - REQ: row_req held high and row_addr held stable until row_ack=1. On ack, capture row_occ/row_color into shadow, set shadow_valid=1, drop row_req the next cycle, and return to IDLE. row_ack while in IDLE is ignored.
- Swap at DrawX==H_LAST:
  - If shadow_valid: active <- shadow, shadow_valid <- 0.
  - Else if need: clear active (all empty) and set underrun=1 (sticky until reset). If the FSM is still in REQ, the request stays pending; data captured later is discarded at the next H_FETCH.
  - Else: active cleared.
- A fetch is issued every line, even if the row is unchanged. This gives a consistent one-line latency for field updates.
- Pixel path:
  - in_field_c = FIELD_X0 <= DrawX < FIELD_X0 + COLS<<CELL_LOG2, and DrawY within the field vertically.
  - col = (DrawX-FIELD_X0)>>CELL_LOG2.
  - Outputs registered: exactly 1 cycle of latency from DrawX/DrawY to is_block/block_color/in_field/is_grid.
  - Outside the field: is_block=0, block_color=7'h7F.
  - Occupancy bit 1 with colour 7'h7F is passed through as is_block=1, block_color=7'h7F.
- Reset deasserted mid-line: operation resumes at the next H_FETCH. The first line after reset displays empty.
- Field store changes between fetches become visible on the line after the next fetch; no tearing within a line.

Optional Feature:
- Macro GRID_LINES_EN.
- Defined: is_grid=1 (registered, same latency) for in-field pixels whose x or y offset within the cell is 0. block_color is unaffected.
- Undefined: is_grid tied to 0; no grid logic present.

Test Plan:
- Reset, then release with the store answering all rows occ=0 -> row_req rises at DrawX=640 with row_addr=0 when DrawY=39; is_block=0 and block_color=7'h7F at every field pixel.
- Store row 5 occ=10'b0000001000, col 3 colour 7'h12 -> pixels DrawX 288..303, DrawY 120..135 give is_block=1, block_color=7'h12 one cycle later; col 2/4 neighbours give 0/7'h7F.
- Ack delayed 20 cycles after row_req -> row_addr stable throughout, row_req drops the cycle after ack, correct data shown on the next line, underrun=0.
- Ack withheld past DrawX=799 on a field line -> next line fully empty, underrun=1 and stays 1 until Reset=0.
- Assert Reset low while row_req=1 -> row_req=0 immediately (asynchronous), all outputs at reset values; clean fetch at the next H_FETCH after release.
- GRID_LINES_EN defined: pixel (240,40) and (256,57) -> is_grid=1; (241,41) -> is_grid=0. Undefined: is_grid=0 everywhere.
